// File: rtl/ultrassonico_emulador_pkg.sv
// Shared state codes, default timing constants and BCD helpers for the HC-SR04 emulator.
package ultrassonico_emulador_pkg;

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        PULSO   = 4'd1,
        RAJADA  = 4'd2,
        ECO     = 4'd3,
        SEM_ECO = 4'd4,
        ESPERA  = 4'd5
    } estado_t;

    localparam int unsigned TRIG_MIN_CYCLES_DEF = 500;
    localparam int unsigned BURST_CYCLES_DEF    = 10000;
    localparam int unsigned CYCLES_PER_CM_DEF   = 2941;
    localparam int unsigned TIMEOUT_CYCLES_DEF  = 1900000;
    localparam int unsigned HOLDOFF_CYCLES_DEF  = 1000000;
    localparam int unsigned MAX_CM_DEF          = 400;

    function automatic int unsigned maximo(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic bcd_invalido(input logic [11:0] v);
        return (v[11:8] > 4'd9) || (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
    endfunction

    // Wide enough for invalid digits too (15*100+15*10+15), so no overflow aliasing.
    function automatic logic [10:0] bcd_para_bin(input logic [11:0] v);
        return 11'(v[11:8]) * 11'd100 + 11'(v[7:4]) * 11'd10 + 11'(v[3:0]);
    endfunction

endpackage

// File: rtl/bcd_contador_decrescente_3d.sv
// Three-digit BCD down-counter with per-digit borrow; holds at 000.
module bcd_contador_decrescente_3d
    import ultrassonico_emulador_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load_i,
    input  logic        dec_i,
    input  logic [11:0] valor_i,
    output logic [11:0] valor_o,
    output logic        zero_o,
    output logic        um_o,
    output logic        invalido_o
);

    logic [11:0] valor_q, valor_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) valor_q <= '0;
        else       valor_q <= valor_d;
    end

    always_comb begin
        valor_d = valor_q;
        if (load_i) begin
            valor_d = valor_i;
        end else if (dec_i && !zero_o) begin
            if (valor_q[3:0] != 4'd0) begin
                valor_d[3:0] = valor_q[3:0] - 4'd1;
            end else begin
                valor_d[3:0] = 4'd9;
                if (valor_q[7:4] != 4'd0) begin
                    valor_d[7:4] = valor_q[7:4] - 4'd1;
                end else begin
                    valor_d[7:4]  = 4'd9;
                    valor_d[11:8] = valor_q[11:8] - 4'd1;
                end
            end
        end
    end

    assign valor_o    = valor_q;
    assign zero_o     = (valor_q == 12'h000);
    assign um_o       = (valor_q == 12'h001);
    assign invalido_o = bcd_invalido(valor_q);

endmodule

// File: rtl/ultrassonico_emulador.sv
// HC-SR04 responder: validates trigger, waits the burst delay, then emits an echo whose width encodes a BCD distance.
module ultrassonico_emulador
    import ultrassonico_emulador_pkg::*;
#(
    parameter int unsigned TRIG_MIN_CYCLES = TRIG_MIN_CYCLES_DEF,
    parameter int unsigned BURST_CYCLES    = BURST_CYCLES_DEF,
    parameter int unsigned CYCLES_PER_CM   = CYCLES_PER_CM_DEF,
    parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
    parameter int unsigned HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF,
    parameter int unsigned MAX_CM          = MAX_CM_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        trigger,
    input  logic [11:0] distancia,
    input  logic        sem_objeto,
    output logic        echo,
    output logic        ocupado,
    output logic        erro_trigger,
    output logic [3:0]  db_estado
);

    localparam int unsigned CNT_MAX = maximo(maximo(TRIG_MIN_CYCLES, BURST_CYCLES),
                                      maximo(maximo(CYCLES_PER_CM, TIMEOUT_CYCLES), HOLDOFF_CYCLES));
    localparam int unsigned CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] TRIG_MIN_C = CW'(TRIG_MIN_CYCLES);
    localparam logic [CW-1:0] BURST_C    = CW'(BURST_CYCLES);
    localparam logic [CW-1:0] TICK_C     = CW'(CYCLES_PER_CM - 1);
    localparam logic [CW-1:0] TIMEOUT_C  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] HOLDOFF_C  = CW'(HOLDOFF_CYCLES - 1);
    localparam logic [10:0]   MAX_CM_C   = 11'(MAX_CM);

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sinc_q;
    logic          trig_ant_q;
    logic          echo_q, echo_d;
    logic          erro_q, erro_d;
    logic          sem_q, sem_d;
    logic          bcd_load, bcd_dec;
    logic [11:0]   bcd_valor;
    logic          bcd_zero, bcd_um, bcd_inv;
    logic          trig_s, trig_sobe, sem_eco;

    assign trig_s    = sinc_q[1];
    assign trig_sobe = trig_s && !trig_ant_q;
    assign sem_eco   = sem_q || bcd_inv || bcd_zero || (bcd_para_bin(bcd_valor) > MAX_CM_C);

    bcd_contador_decrescente_3d u_bcd (
        .clock      (clock),
        .reset      (reset),
        .load_i     (bcd_load),
        .dec_i      (bcd_dec),
        .valor_i    (distancia),
        .valor_o    (bcd_valor),
        .zero_o     (bcd_zero),
        .um_o       (bcd_um),
        .invalido_o (bcd_inv)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= INICIAL;
            cnt_q      <= '0;
            sinc_q     <= '0;
            trig_ant_q <= 1'b0;
            echo_q     <= 1'b0;
            erro_q     <= 1'b0;
            sem_q      <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            cnt_q      <= cnt_d;
            sinc_q     <= {sinc_q[0], trigger};
            trig_ant_q <= trig_s;
            echo_q     <= echo_d;
            erro_q     <= erro_d;
            sem_q      <= sem_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        echo_d   = echo_q;
        erro_d   = 1'b0;
        sem_d    = sem_q;
        bcd_load = 1'b0;
        bcd_dec  = 1'b0;
        case (estado_q)
            INICIAL: begin
                // The cycle that reveals the rising edge is itself a high cycle, so counting starts at 1.
                if (trig_sobe) begin
                    estado_d = PULSO;
                    cnt_d    = CW'(1);
                end
            end
            PULSO: begin
                if (trig_s) begin
                    if (cnt_q < TRIG_MIN_C) cnt_d = cnt_q + CW'(1);
                end else if (cnt_q >= TRIG_MIN_C) begin
                    estado_d = RAJADA;
                    cnt_d    = '0;
                    bcd_load = 1'b1;
                    sem_d    = sem_objeto;
                end else begin
                    estado_d = INICIAL;
                    cnt_d    = '0;
                    erro_d   = 1'b1;
                end
            end
            RAJADA: begin
                if (cnt_q == BURST_C) begin
                    cnt_d    = '0;
                    echo_d   = 1'b1;
                    estado_d = sem_eco ? SEM_ECO : ECO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ECO: begin
                if (cnt_q == TICK_C) begin
                    cnt_d   = '0;
                    bcd_dec = 1'b1;
                    if (bcd_um) begin
                        echo_d   = 1'b0;
                        estado_d = ESPERA;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SEM_ECO: begin
                if (cnt_q == TIMEOUT_C) begin
                    cnt_d    = '0;
                    echo_d   = 1'b0;
                    estado_d = ESPERA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ESPERA: begin
                if (cnt_q == HOLDOFF_C) begin
                    cnt_d    = '0;
                    estado_d = INICIAL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                estado_d = INICIAL;
                cnt_d    = '0;
                echo_d   = 1'b0;
            end
        endcase
    end

    assign echo         = echo_q;
    assign erro_trigger = erro_q;
    assign ocupado      = (estado_q != INICIAL);
    assign db_estado    = estado_q;

endmodule

// File: tb/tb_ultrassonico_emulador.sv
// Directed self-checking bench for ultrassonico_emulador with shortened timing parameters.
module tb_ultrassonico_emulador;

    localparam int LAT     = 23;
    localparam int HOLDOFF = 50;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        trigger = 1'b0;
    logic [11:0] distancia = 12'h000;
    logic        sem_objeto = 1'b0;
    logic        echo, ocupado, erro_trigger;
    logic [3:0]  db_estado;

    ultrassonico_emulador #(
        .TRIG_MIN_CYCLES (5),
        .BURST_CYCLES    (20),
        .CYCLES_PER_CM   (3),
        .TIMEOUT_CYCLES  (100),
        .HOLDOFF_CYCLES  (50),
        .MAX_CM          (400)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .trigger      (trigger),
        .distancia    (distancia),
        .sem_objeto   (sem_objeto),
        .echo         (echo),
        .ocupado      (ocupado),
        .erro_trigger (erro_trigger),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int err_pulses = 0;
    int err_at = -1;
    int echo_hi = 0;

    always @(negedge clock) begin
        if (erro_trigger) begin
            err_pulses++;
            err_at = cyc;
        end
        if (echo) echo_hi++;
    end

    typedef struct {
        logic [11:0] d;
        logic        s;
        int          w;
        int          st;
    } vec_t;

    vec_t tab[9];

    task automatic chk(input string nome, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nome, act, exp);
        end
    endtask

    task automatic wait_sig(input int which, input logic lvl, input int lim, input string nome, output int at);
        at = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clock);
            if (((which == 0) ? echo : ocupado) == lvl) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no transition within %0d cycles", nome, lim);
        end
    endtask

    // f = index of the first edge that samples the trigger pin low.
    task automatic pulse(input int n, output int f);
        @(posedge clock);
        #1 trigger = 1'b1;
        repeat (n) @(posedge clock);
        #1 trigger = 1'b0;
        f = cyc + 1;
    endtask

    task automatic run_meas(input string nome, input logic [11:0] d, input logic s,
                            input int plen, input int exp_w, input int exp_st);
        int f, r, e, o;
        distancia  = d;
        sem_objeto = s;
        pulse(plen, f);
        wait_sig(0, 1'b1, 60, {nome, " rise"}, r);
        chk({nome, " latency"}, r - f, LAT);
        chk({nome, " state"}, int'(db_estado), exp_st);
        wait_sig(0, 1'b0, exp_w + 40, {nome, " fall"}, e);
        chk({nome, " width"}, e - r, exp_w);
        wait_sig(1, 1'b0, 100, {nome, " idle"}, o);
        chk({nome, " holdoff"}, o - e, HOLDOFF);
        chk({nome, " idle state"}, int'(db_estado), 0);
        repeat (3) @(posedge clock);
    endtask

    task automatic short_pulse(input string nome, input int n);
        int f, p0, e0;
        p0 = err_pulses;
        e0 = echo_hi;
        pulse(n, f);
        repeat (10) @(negedge clock);
        chk({nome, " err count"}, err_pulses - p0, 1);
        chk({nome, " err timing"}, err_at - f, 2);
        chk({nome, " no echo"}, echo_hi - e0, 0);
        chk({nome, " state"}, int'(db_estado), 0);
    endtask

    initial begin
        int f, r, e, o, p0, bad;

        tab[0] = '{12'h025, 1'b0,   75, 3};
        tab[1] = '{12'h025, 1'b1,  100, 4};
        tab[2] = '{12'h401, 1'b0,  100, 4};
        tab[3] = '{12'h0A0, 1'b0,  100, 4};
        tab[4] = '{12'h000, 1'b0,  100, 4};
        tab[5] = '{12'h09A, 1'b0,  100, 4};
        tab[6] = '{12'h400, 1'b0, 1200, 3};
        tab[7] = '{12'h001, 1'b0,    3, 3};
        tab[8] = '{12'h100, 1'b0,  300, 3};

        repeat (3) @(negedge clock);
        chk("por echo", int'(echo), 0);
        chk("por ocupado", int'(ocupado), 0);
        chk("por erro", int'(erro_trigger), 0);
        chk("por estado", int'(db_estado), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("post-reset estado", int'(db_estado), 0);

        for (int i = 0; i < 9; i++)
            run_meas($sformatf("vec%0d", i), tab[i].d, tab[i].s, 10, tab[i].w, tab[i].st);

        short_pulse("short3", 3);
        short_pulse("short4", 4);
        run_meas("min5", 12'h002, 1'b0, 5, 6, 3);

        // Extra triggers during ECO and ESPERA, plus a distance change mid-echo.
        p0 = err_pulses;
        distancia = 12'h025;
        sem_objeto = 1'b0;
        pulse(10, f);
        wait_sig(0, 1'b1, 60, "ign rise", r);
        fork
            begin
                repeat (10) @(posedge clock);
                #1 trigger = 1'b1;
                distancia = 12'h399;
                repeat (8) @(posedge clock);
                #1 trigger = 1'b0;
            end
        join_none
        wait_sig(0, 1'b0, 120, "ign fall", e);
        chk("ign width", e - r, 75);
        @(posedge clock);
        #1 trigger = 1'b1;
        repeat (10) @(posedge clock);
        #1 trigger = 1'b0;
        wait_sig(1, 1'b0, 100, "ign idle", o);
        chk("ign holdoff", o - e, HOLDOFF);
        bad = 0;
        repeat (40) begin
            @(negedge clock);
            if (db_estado != 4'd0 || echo) bad++;
        end
        chk("ign no new meas", bad, 0);
        chk("ign no err", err_pulses - p0, 0);

        // Trigger held high across the ESPERA exit.
        distancia = 12'h003;
        pulse(10, f);
        wait_sig(0, 1'b1, 60, "hold rise", r);
        wait_sig(0, 1'b0, 60, "hold fall", e);
        chk("hold width", e - r, 9);
        @(posedge clock);
        #1 trigger = 1'b1;
        wait_sig(1, 1'b0, 100, "hold idle", o);
        chk("hold holdoff", o - e, HOLDOFF);
        bad = 0;
        repeat (30) begin
            @(negedge clock);
            if (db_estado != 4'd0 || echo) bad++;
        end
        chk("hold no meas", bad, 0);
        @(posedge clock);
        #1 trigger = 1'b0;
        repeat (5) @(posedge clock);
        run_meas("after hold", 12'h010, 1'b0, 10, 30, 3);

        // Asynchronous reset in the middle of an echo.
        distancia = 12'h025;
        pulse(10, f);
        wait_sig(0, 1'b1, 60, "rst rise", r);
        repeat (10) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rst echo", int'(echo), 0);
        chk("rst ocupado", int'(ocupado), 0);
        chk("rst estado", int'(db_estado), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        run_meas("after rst", 12'h004, 1'b0, 10, 12, 3);

        // Reset while idle.
        #2 reset = 1'b1;
        #1;
        chk("idle rst echo", int'(echo), 0);
        chk("idle rst estado", int'(db_estado), 0);
        chk("idle rst erro", int'(erro_trigger), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
